uart_string_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single framed-string UART transmit channel (`{{payload}}` format, 1024-bit string, 8-bit length, tx_req/tx_busy/tx_done handshake) among NUM_REQ report sources.
- Each source posts a one-cycle request and holds its string and length stable until it receives a done pulse.
- The arbiter issues the request to the string channel, supervises completion with a timeout, and returns per-source done and error status.
- It sits between the application report logic and the UART string handler.

---
 rtl/uart_string_tx_arbiter_pkg.sv | 23 ++
 rtl/uart_string_tx_arbiter_rr_pick.sv | 31 +++
 rtl/uart_string_tx_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_uart_string_tx_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_string_tx_arbiter_pkg.sv
// Shared constants for the UART string transmit arbiter: FSM encodings,
// error codes, channel field widths and a small one-hot helper.
package uart_string_tx_arbiter_pkg;

  localparam int STR_W = 1024;
  localparam int LEN_W = 8;

  localparam logic [4:0] ST_IDLE      = 5'b00001;
  localparam logic [4:0] ST_ISSUE     = 5'b00010;
  localparam logic [4:0] ST_WAIT_BUSY = 5'b00100;
  localparam logic [4:0] ST_WAIT_DONE = 5'b01000;
  localparam logic [4:0] ST_RELEASE   = 5'b10000;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ZERO_LEN = 2'b01;
  localparam logic [1:0] ERR_NO_BUSY  = 2'b10;
  localparam logic [1:0] ERR_DONE_TO  = 2'b11;

  function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/uart_string_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of pending_i searching
// upward from ptr_i+1 with wrap-around.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     pending_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  int cand_s;

  // Walk offsets from farthest to nearest so the nearest pending bit wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand_s  = 0;
    for (int off = N; off >= 1; off--) begin
      cand_s = (int'(ptr_i) + off) % N;
      if (pending_i[cand_s[IDX_W-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand_s[IDX_W-1:0];
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/uart_string_tx_arbiter.sv
// Round-robin arbiter sharing one framed-string UART transmit channel among
// NUM_REQ report sources, with completion timeout and per-source status.
module uart_string_tx_arbiter
  import uart_string_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [NUM_REQ-1:0]         src_req,
  input  logic [NUM_REQ*STR_W-1:0]   src_string,
  input  logic [NUM_REQ*LEN_W-1:0]   src_length,
  output logic [NUM_REQ-1:0]         src_pending,
  output logic [NUM_REQ-1:0]         src_done,
  output logic                       src_err,
  output logic [1:0]                 err_code,
  output logic [STR_W-1:0]           ch_tx_string,
  output logic [LEN_W-1:0]           ch_tx_length,
  output logic                       ch_tx_req,
  input  logic                       ch_tx_busy,
  input  logic                       ch_tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [4:0]         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         err_q, err_d;
  logic [STR_W-1:0]   str_q, str_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               req_q, req_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               serr_q, serr_d;
  logic [1:0]         code_q, code_d;

  logic               pick_valid_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic [NUM_REQ-1:0] clr_s;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .pending_i (pend_q),
    .ptr_i     (ptr_q),
    .valid_o   (pick_valid_s),
    .idx_o     (pick_idx_s)
  );

  // Next-state logic for the grant FSM, timeout counter and pulse outputs.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    str_d     = str_q;
    len_d     = len_q;
    req_d     = 1'b0;
    cnt_inc_s = cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (!ch_tx_busy && pick_valid_s) begin
          grant_d = pick_idx_s;
          str_d   = src_string[int'(pick_idx_s)*STR_W +: STR_W];
          len_d   = src_length[int'(pick_idx_s)*LEN_W +: LEN_W];
          if (len_d == 8'd0) begin
            err_d   = ERR_ZERO_LEN;
            state_d = ST_RELEASE;
          end else begin
            err_d   = ERR_NONE;
            req_d   = 1'b1;
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      // A done seen before busy is still a completed frame.
      ST_WAIT_BUSY: begin
        cnt_d = cnt_inc_s;
        if (ch_tx_done) begin
          state_d = ST_RELEASE;
        end else if (ch_tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_inc_s == TO_LAST) begin
          err_d   = ERR_NO_BUSY;
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_inc_s;
        if (ch_tx_done) begin
          state_d = ST_RELEASE;
        end else if (cnt_inc_s == TO_LAST) begin
          err_d   = ERR_DONE_TO;
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_RELEASE: begin
        ptr_d   = grant_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_RELEASE) begin
      done_d = NUM_REQ'(idx_to_onehot(3'(grant_d)));
      serr_d = (err_d != ERR_NONE);
      code_d = err_d;
    end else begin
      done_d = '0;
      serr_d = 1'b0;
      code_d = ERR_NONE;
    end

    // A request landing in the release cycle keeps the bit set.
    if (state_q == ST_RELEASE) begin
      clr_s = NUM_REQ'(idx_to_onehot(3'(grant_q)));
    end else begin
      clr_s = '0;
    end
    pend_d = (pend_q & ~clr_s) | src_req;
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      pend_q  <= '0;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
      str_q   <= '0;
      len_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= '0;
      serr_q  <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      str_q   <= str_d;
      len_q   <= len_d;
      req_q   <= req_d;
      done_q  <= done_d;
      serr_q  <= serr_d;
      code_q  <= code_d;
    end
  end

  assign src_pending  = pend_q;
  assign src_done     = done_q;
  assign src_err      = serr_q;
  assign err_code     = code_q;
  assign ch_tx_string = str_q;
  assign ch_tx_length = len_q;
  assign ch_tx_req    = req_q;
  assign grant_idx    = grant_q;

endmodule

// File: tb/tb_uart_string_tx_arbiter.sv
// Directed bench for uart_string_tx_arbiter: a table of single transfers
// plus hand-written multi-cycle sequences, with a scripted channel model.
module tb_uart_string_tx_arbiter;

  logic           clk;
  logic           sys_rst_n;
  logic [3:0]     src_req;
  logic [4095:0]  src_string;
  logic [31:0]    src_length;
  logic [3:0]     src_pending;
  logic [3:0]     src_done;
  logic           src_err;
  logic [1:0]     err_code;
  logic [1023:0]  ch_tx_string;
  logic [7:0]     ch_tx_length;
  logic           ch_tx_req;
  logic           ch_tx_busy;
  logic           ch_tx_done;
  logic [1:0]     grant_idx;

  uart_string_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(100)) dut (
    .sys_clk      (clk),
    .sys_rst_n    (sys_rst_n),
    .src_req      (src_req),
    .src_string   (src_string),
    .src_length   (src_length),
    .src_pending  (src_pending),
    .src_done     (src_done),
    .src_err      (src_err),
    .err_code     (err_code),
    .ch_tx_string (ch_tx_string),
    .ch_tx_length (ch_tx_length),
    .ch_tx_req    (ch_tx_req),
    .ch_tx_busy   (ch_tx_busy),
    .ch_tx_done   (ch_tx_done),
    .grant_idx    (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int done_cnt = 0;
  int gq[$];
  int mode = 0;   // channel: 0 normal, 1 never busy, 2 busy without done
  int k = 0;

  typedef struct {
    int         idx;
    logic [7:0] len;
    logic [39:0] txt;
    int         mode;
    logic       err;
    logic [1:0] code;
    int         req_off;
    int         done_off;
  } vec_t;
  vec_t vt[5];

  logic [1023:0] s;
  logic [1023:0] got_str;
  logic [7:0]    got_len;
  logic [3:0]    got_done;
  logic          got_err;
  logic [1:0]    got_code;
  logic [1:0]    got_grant;
  int            req_seen, done_seen, base, base_req, base_done, issued;
  logic          seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel: busy for three cycles from the request, then a done pulse.
  initial begin
    ch_tx_busy = 1'b0;
    ch_tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ch_tx_done = 1'b0;
      if (ch_tx_req && mode != 1) begin
        ch_tx_busy = 1'b1;
        k = 1;
      end else if (k == 1 || k == 2) begin
        k++;
        ch_tx_busy = 1'b1;
      end else if (k == 3) begin
        if (mode == 2) begin
          ch_tx_busy = 1'b1;
        end else begin
          k = 0;
          ch_tx_busy = 1'b0;
          ch_tx_done = 1'b1;
        end
      end else begin
        ch_tx_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ch_tx_req) begin
        req_cnt++;
        gq.push_back(int'(grant_idx));
      end
      if (src_done != 4'd0) begin
        done_cnt++;
        chk("done_onehot", 64'($countones(src_done)), 64'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 8'd5,   "HELLO", 0, 1'b0, 2'b00, 2,  6};
    vt[1] = '{3, 8'd200, "WORLD", 0, 1'b0, 2'b00, 2,  6};
    vt[2] = '{1, 8'd0,   "EMPTY", 0, 1'b1, 2'b01, -1, 2};
    vt[3] = '{2, 8'd1,   "NOBSY", 1, 1'b1, 2'b10, 2,  102};
    vt[4] = '{2, 8'd7,   "NODNE", 2, 1'b1, 2'b11, 2,  102};

    sys_rst_n  = 1'b0;
    src_req    = 4'd0;
    src_string = '0;
    src_length = 32'd0;
    repeat (3) tick();
    chk("rst_outs", 64'({src_pending, src_done, src_err, err_code, ch_tx_req, ch_tx_length, grant_idx}), 64'd0);
    chk("rst_str", 64'(|ch_tx_string), 64'd0);
    sys_rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_outs", 64'({src_pending, src_done, src_err, ch_tx_req}), 64'd0);

    for (int r = 0; r < 5; r++) begin
      s = '0;
      s[39:0] = vt[r].txt;
      src_string[vt[r].idx*1024 +: 1024] = s;
      src_length[vt[r].idx*8 +: 8] = vt[r].len;
      mode = vt[r].mode;
      req_seen = -1;
      done_seen = -1;
      src_req = 4'd0;
      src_req[vt[r].idx] = 1'b1;
      tick();
      src_req = 4'd0;
      for (int c = 1; c <= 150 && done_seen < 0; c++) begin
        if (ch_tx_req && req_seen < 0) begin
          req_seen = c;
          got_len = ch_tx_length;
          got_str = ch_tx_string;
        end
        if (src_done != 4'd0) begin
          done_seen = c;
          got_done  = src_done;
          got_err   = src_err;
          got_code  = err_code;
          got_grant = grant_idx;
        end
        if (done_seen < 0) tick();
      end
      chk("req_latency", 64'(req_seen), 64'(vt[r].req_off));
      chk("done_latency", 64'(done_seen), 64'(vt[r].done_off));
      chk("done_vec", 64'(got_done), 64'(4'd1 << vt[r].idx));
      chk("err", 64'(got_err), 64'(vt[r].err));
      chk("err_code", 64'(got_code), 64'(vt[r].code));
      chk("grant", 64'(got_grant), 64'(vt[r].idx));
      if (vt[r].req_off > 0) begin
        chk("ch_len", 64'(got_len), 64'(vt[r].len));
        chk("ch_str", got_str[63:0], s[63:0]);
      end
      mode = 0;
      repeat (8) tick();
      chk("pend_clear", 64'(src_pending), 64'd0);
    end

    // Fairness: 0 and 2 each re-request at their done pulse.
    base = gq.size();
    src_req = 4'b0101;
    tick();
    src_req = 4'd0;
    issued = 2;
    for (int c = 0; c < 200; c++) begin
      if (src_done != 4'd0 && issued < 4) begin
        src_req = src_done;
        issued++;
      end
      tick();
      src_req = 4'd0;
    end
    chk("fair_count", 64'(gq.size() - base), 64'd4);
    if (gq.size() - base == 4) begin
      chk("fair_g0", 64'(gq[base]),   64'd0);
      chk("fair_g1", 64'(gq[base+1]), 64'd2);
      chk("fair_g2", 64'(gq[base+2]), 64'd0);
      chk("fair_g3", 64'(gq[base+3]), 64'd2);
    end

    // Request coinciding with the release of the same source.
    base = gq.size();
    seen = 1'b0;
    src_req = 4'b0100;
    tick();
    src_req = 4'd0;
    for (int c = 0; c < 100; c++) begin
      if (src_done[2] && !seen) begin
        seen = 1'b1;
        src_req = 4'b0100;
        tick();
        src_req = 4'd0;
        chk("setwins_pend", 64'(src_pending[2]), 64'd1);
      end else begin
        tick();
      end
    end
    chk("setwins_count", 64'(gq.size() - base), 64'd2);
    chk("setwins_pend_end", 64'(src_pending), 64'd0);

    // Reset while waiting for the channel done.
    mode = 2;
    src_length[15:8] = 8'd4;
    src_req = 4'b0010;
    tick();
    src_req = 4'd0;
    for (int c = 0; c < 20 && !ch_tx_req; c++) tick();
    chk("rst6_issue", 64'(ch_tx_req), 64'd1);
    repeat (4) tick();
    base_done = done_cnt;
    sys_rst_n = 1'b0;
    #1;
    chk("rst6_outs", 64'({src_pending, src_done, src_err, err_code, ch_tx_req, ch_tx_length, grant_idx}), 64'd0);
    mode = 0;
    repeat (4) tick();
    sys_rst_n = 1'b1;
    repeat (2) tick();
    chk("rst6_nodone", 64'(done_cnt - base_done), 64'd0);
    chk("rst6_pend", 64'(src_pending), 64'd0);

    // All four sources at once after reset: served 0,1,2,3.
    src_length = {8'd3, 8'd3, 8'd3, 8'd3};
    base = gq.size();
    base_req = req_cnt;
    base_done = done_cnt;
    src_req = 4'b1111;
    tick();
    src_req = 4'd0;
    for (int c = 0; c < 100 && (done_cnt - base_done) < 4; c++) tick();
    repeat (10) tick();
    chk("all4_reqs", 64'(req_cnt - base_req), 64'd4);
    chk("all4_dones", 64'(done_cnt - base_done), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < gq.size()) begin
        chk("all4_order", 64'(gq[base+i]), 64'(i));
      end else begin
        chk("all4_missing", 64'd1, 64'd0);
      end
    end
    chk("all4_pend", 64'(src_pending), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
